// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time over a req/ack data-memory port.
// Define LSU_TIMEOUT_EN to bound the ack wait to TIMEOUT_CYCLES busy cycles.
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] alu_data,
    input  logic [31:0] rs2_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    // Handshake: dmem_req rises on BUSY entry and all request fields stay frozen
    // until the rising edge on which dmem_ack=1 is sampled; ack outside BUSY is ignored.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;

    logic        is_mem;
    logic        aligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
    logic [31:0] wait_cnt;
`endif

    assign is_mem    = ex_is_load | ex_is_store;
    assign lsu_stall = ((state == IDLE) & ex_valid & is_mem) | (state == BUSY);

    // funct3[1:0] alone selects the access width; reserved codes all land on W.
    always_comb begin
        aligned    = 1'b1;
        be_next    = 4'b1111;
        wdata_next = rs2_data;
        case (ex_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << alu_data[1:0];
                wdata_next = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                aligned    = ~alu_data[0];
                be_next    = 4'b0011 << alu_data[1:0];
                wdata_next = {2{rs2_data[15:0]}};
            end
            default: begin
                aligned    = (alu_data[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = rs2_data;
            end
        endcase
    end

    always_comb begin
        lane_b = dmem_rdata[7:0];
        case (off_q)
            2'd0: lane_b = dmem_rdata[7:0];
            2'd1: lane_b = dmem_rdata[15:8];
            2'd2: lane_b = dmem_rdata[23:16];
            2'd3: lane_b = dmem_rdata[31:24];
            default: lane_b = dmem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off_q      <= 2'd0;
            funct3_q   <= 3'd0;
            lsu_done   <= 1'b0;
            lsu_err    <= 1'b0;
            lsu_rdata  <= 32'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt   <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ex_valid && is_mem) begin
                        if (aligned) begin
                            state      <= BUSY;
                            off_q      <= alu_data[1:0];
                            funct3_q   <= ex_funct3;
                            dmem_req   <= 1'b1;
                            dmem_we    <= ex_is_store;
                            dmem_addr  <= {alu_data[31:2], 2'b00};
                            dmem_wdata <= wdata_next;
                            dmem_be    <= be_next;
`ifdef LSU_TIMEOUT_EN
                            wait_cnt   <= 32'd0;
`endif
                        end else begin
                            // Misaligned: fault without touching memory.
                            state    <= DONE;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        lsu_done <= 1'b1;
                        if (!dmem_we) begin
                            lsu_rdata <= load_ext;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (wait_cnt + 32'd1 >= TIMEOUT_CYCLES) begin
                        state    <= DONE;
                        dmem_req <= 1'b0;
                        lsu_done <= 1'b1;
                        lsu_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
`endif
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
